// File: rtl/axil_wr_rd_checker.sv
// axil_wr_rd_checker: AXI4-Lite master that writes, reads back and
// compares NUM_REGS registers of a slave, then reports the outcome.
//
// Ports:
//   ACLK, ARESET      clock, synchronous active-high reset
//   start, test_data  run request and per-register write patterns
//   busy, done, pass  run status (pass valid with done, then held)
//   err_count         errors in last run, saturating at 31
//   first_err_idx     register index of the first error
//   first_err_code    01 bad resp, 10 data mismatch, 11 timeout
//   M_AXI_*           AXI4-Lite master (AW, W, B, AR, R channels)
module axil_wr_rd_checker #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int ADDR_STRIDE = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic                           start,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] test_data,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [4:0]                     err_count,
  output logic [3:0]                     first_err_idx,
  output logic [1:0]                     first_err_code,
  output logic [ADDR_WIDTH-1:0]          M_AXI_AWADDR,
  output logic [2:0]                     M_AXI_AWPROT,
  output logic                           M_AXI_AWVALID,
  input  logic                           M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]          M_AXI_WDATA,
  output logic [3:0]                     M_AXI_WSTRB,
  output logic                           M_AXI_WVALID,
  input  logic                           M_AXI_WREADY,
  input  logic [1:0]                     M_AXI_BRESP,
  input  logic                           M_AXI_BVALID,
  output logic                           M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]          M_AXI_ARADDR,
  output logic [2:0]                     M_AXI_ARPROT,
  output logic                           M_AXI_ARVALID,
  input  logic                           M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]          M_AXI_RDATA,
  input  logic [1:0]                     M_AXI_RRESP,
  input  logic                           M_AXI_RVALID,
  output logic                           M_AXI_RREADY
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE =
    ADDR_WIDTH'(ADDR_STRIDE);
  localparam logic [1:0] E_RESP = 2'b01;
  localparam logic [1:0] E_DATA = 2'b10;
  localparam logic [1:0] E_TMO  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WRESP, S_RD, S_RDATA, S_CMP, S_FIN
  } state_t;

  state_t state_q, state_d;

  logic [3:0]                     idx_q;
  logic [ADDR_WIDTH-1:0]          addr_q;
  logic [NUM_REGS*DATA_WIDTH-1:0] pat_q;
  logic [DATA_WIDTH-1:0]          pat_w;
  logic [DATA_WIDTH-1:0]          rdata_q;
  logic                           aw_done_q;
  logic                           w_done_q;
  logic                           logged_q;
  logic [TW-1:0]                  tmo_q;
  logic [4:0]                     err_q;
  logic [3:0]                     fidx_q;
  logic [1:0]                     fcode_q;
  logic                           pass_q;

  logic       aw_hs;
  logic       w_hs;
  logic       wr_ok;
  logic       tmo_hit;
  logic       wait_st;
  logic       log_en;
  logic       do_log;
  logic [1:0] log_code;

  assign pat_w = pat_q[idx_q*DATA_WIDTH +: DATA_WIDTH];

  assign aw_hs   = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs    = M_AXI_WVALID & M_AXI_WREADY;
  assign wr_ok   = (aw_done_q | aw_hs) & (w_done_q | w_hs);
  assign tmo_hit = (tmo_q == TMO_LAST);
  assign wait_st = state_q inside
    {S_WR, S_WRESP, S_RD, S_RDATA};

  // State register
  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (start) state_d = S_WR;
      S_WR:
        if (wr_ok)        state_d = S_WRESP;
        else if (tmo_hit) state_d = S_FIN;
      S_WRESP:
        if (M_AXI_BVALID) state_d = S_RD;
        else if (tmo_hit) state_d = S_FIN;
      S_RD:
        if (M_AXI_ARREADY) state_d = S_RDATA;
        else if (tmo_hit)  state_d = S_FIN;
      S_RDATA:
        if (M_AXI_RVALID) state_d = S_CMP;
        else if (tmo_hit) state_d = S_FIN;
      S_CMP:
        state_d = (idx_q == LAST_IDX) ? S_FIN : S_WR;
      S_FIN:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // Outputs: decoded from registers only
  always_comb begin
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    unique case (state_q)
      S_WR: begin
        M_AXI_AWVALID = ~aw_done_q;
        M_AXI_WVALID  = ~w_done_q;
      end
      S_WRESP: M_AXI_BREADY  = 1'b1;
      S_RD:    M_AXI_ARVALID = 1'b1;
      S_RDATA: M_AXI_RREADY  = 1'b1;
      default: ;
    endcase
    busy = (state_q != S_IDLE);
    done = (state_q == S_FIN);
    pass = done ? (err_q == 5'd0) : pass_q;
  end

  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = pat_w;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB  = 4'hF;

  assign err_count      = err_q;
  assign first_err_idx  = fidx_q;
  assign first_err_code = fcode_q;

  // Error source for this cycle
  always_comb begin
    log_en   = 1'b0;
    log_code = E_RESP;
    unique case (state_q)
      S_WR:
        if (!wr_ok && tmo_hit) begin
          log_en   = 1'b1;
          log_code = E_TMO;
        end
      S_WRESP:
        if (M_AXI_BVALID) begin
          log_en = (M_AXI_BRESP != 2'b00);
        end else if (tmo_hit) begin
          log_en   = 1'b1;
          log_code = E_TMO;
        end
      S_RD:
        if (!M_AXI_ARREADY && tmo_hit) begin
          log_en   = 1'b1;
          log_code = E_TMO;
        end
      S_RDATA:
        if (M_AXI_RVALID) begin
          log_en = (M_AXI_RRESP != 2'b00);
        end else if (tmo_hit) begin
          log_en   = 1'b1;
          log_code = E_TMO;
        end
      S_CMP:
        if (rdata_q != pat_w) begin
          log_en   = 1'b1;
          log_code = E_DATA;
        end
      default: ;
    endcase
  end

  // One error per register index at most
  assign do_log = log_en & ~logged_q;

  // Datapath
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      idx_q     <= '0;
      addr_q    <= BASE_ADDR;
      pat_q     <= '0;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      logged_q  <= 1'b0;
      tmo_q     <= '0;
      err_q     <= '0;
      fidx_q    <= '0;
      fcode_q   <= '0;
      pass_q    <= 1'b0;
    end else begin
      if (!wait_st || state_d != state_q)
        tmo_q <= '0;
      else
        tmo_q <= tmo_q + 1'b1;

      // Per-channel done flags clear on WR exit
      if (state_q == S_WR) begin
        aw_done_q <= (state_d == S_WR) &
                     (aw_done_q | aw_hs);
        w_done_q  <= (state_d == S_WR) &
                     (w_done_q | w_hs);
      end

      if (state_q == S_RDATA && M_AXI_RVALID)
        rdata_q <= M_AXI_RDATA;

      if (do_log) begin
        logged_q <= 1'b1;
        if (err_q != 5'd31)
          err_q <= err_q + 5'd1;
        if (err_q == 5'd0) begin
          fidx_q  <= idx_q;
          fcode_q <= log_code;
        end
      end

      if (state_q == S_CMP) begin
        logged_q <= 1'b0;
        if (idx_q != LAST_IDX) begin
          idx_q  <= idx_q + 4'd1;
          addr_q <= addr_q + STRIDE;
        end
      end

      if (state_q == S_FIN)
        pass_q <= (err_q == 5'd0);

      if (state_q == S_IDLE && start) begin
        pat_q    <= test_data;
        idx_q    <= '0;
        addr_q   <= BASE_ADDR;
        err_q    <= '0;
        fidx_q   <= '0;
        fcode_q  <= '0;
        pass_q   <= 1'b0;
        logged_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/axil_wr_rd_checker.md
Name: axil_wr_rd_checker

Overview:
- Hardware AXI4-Lite master that drives the myip register slave on-chip, replacing the simulation BFM stimulus in board bring-up.
- On start, for each of NUM_REGS registers: concurrent write (AW+W) -> B response -> read (AR) -> R data -> compare.
- Reports pass/fail, error count and first-failure details to the PS.
- Sits directly upstream of the S00_AXI slave port.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width (only 32 supported)
NUM_REGS, 4, registers exercised per run (1..16)
BASE_ADDR, 32'h0, address of first register
ADDR_STRIDE, 4, byte increment between registers
TIMEOUT_CYCLES, 1024, max cycles waited per channel handshake

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous reset, active-high
start  in  1  single-cycle pulse; ignored unless idle
test_data  in  NUM_REGS*DATA_WIDTH  write patterns, reg i = bits [i*32+:32]; sampled at start
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse at run end
pass  out  1  valid with done, held until next start; 1 = zero errors
err_count  out  5  errors in last run (saturates at 31)
first_err_idx  out  4  register index of first error
first_err_code  out  2  01 bad resp, 10 data mismatch, 11 timeout
M_AXI_AWADDR  out  ADDR_WIDTH
M_AXI_AWPROT  out  3  constant 0
M_AXI_AWVALID  out  1
M_AXI_AWREADY  in  1
M_AXI_WDATA  out  DATA_WIDTH
M_AXI_WSTRB  out  4  constant 4'hF
M_AXI_WVALID  out  1
M_AXI_WREADY  in  1
M_AXI_BRESP  in  2
M_AXI_BVALID  in  1
M_AXI_BREADY  out  1
M_AXI_ARADDR  out  ADDR_WIDTH
M_AXI_ARPROT  out  3  constant 0
M_AXI_ARVALID  out  1
M_AXI_ARREADY  in  1
M_AXI_RDATA  in  DATA_WIDTH
M_AXI_RRESP  in  2
M_AXI_RVALID  in  1
M_AXI_RREADY  out  1

Behaviour:
- Reset: all VALID/READY outputs 0, busy 0, done 0, pass 0, err_count 0, first_err_idx 0, first_err_code 0, FSM IDLE, index 0. Reset mid-run aborts immediately; no done pulse; next start begins cleanly.
- FSM states: IDLE -> WR (start) -> WRESP -> RD -> RDATA -> CMP -> WR (next index) or FIN -> IDLE.
- IDLE: on start, latch test_data, index=0, addr=BASE_ADDR, clear err_count/first_err_*, busy=1 next cycle.
- WR: AWVALID and WVALID asserted the same cycle. Each drops independently after its own handshake (VALID&READY). Leave when both are done. VALID never drops before its handshake.
- WRESP: BREADY=1 until BVALID. BRESP!=00 logs code 01.
- RD: ARVALID with ARADDR=addr until ARREADY.
- RDATA: RREADY=1 until RVALID; capture RDATA. RRESP!=00 logs 01.
- CMP: one cycle. RDATA!=latched pattern logs 10. Compare is skipped if this index already logged an error.
- Index step: index+1, addr+ADDR_STRIDE (ADDR_WIDTH wrap-around allowed). After index NUM_REGS-1 go to FIN.
- FIN: done=1 for one cycle, pass=(err_count==0), busy=0 next cycle.
- Timeout: per-state counter reset on state entry. Reaching TIMEOUT_CYCLES logs 11, drops all VALID/READY, goes to FIN (run aborted).
- Error logging: at most one error per index. err_count saturates at 31. first_err_* written only when err_count was 0.
- Minimum latency per register with always-ready slave: 1 (WR) + 1 (WRESP) + 1 (RD) + 1 (RDATA) + 1 (CMP) = 5 cycles. Full run = 5*NUM_REGS + 1 cycles from start to done.
- start while busy: ignored. start in the same cycle as ARESET: reset wins.
- Outputs are registered; no combinational path from AXI inputs to AXI outputs.

Test Plan:
- Ideal slave (always-ready register file), patterns 0101FFFF/abcd0001/dead0011/beef0011 at BASE 0 -> 4 writes and 4 reads at addresses 0,4,8,C; done at cycle 21; pass=1, err_count=0.
- AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held stable with AWADDR constant for 4 cycles; B is not awaited until both handshakes complete; pass=1.
- Slave corrupts reg 2 readback to dead0010 -> err_count=1, first_err_idx=2, first_err_code=10, pass=0.
- BRESP=10 on reg 1 and data mismatch on reg 1 -> single error logged for reg 1, code 01, err_count=1.
- ARREADY stuck low on reg 0 with TIMEOUT_CYCLES=16 -> ARVALID drops after 16 cycles, done pulse, code 11, idx 0, pass=0.
- ARESET asserted during RDATA of reg 1, then start -> no done for the aborted run; outputs at reset values; fresh run passes with index from 0.
